mdio_cmd_arbiter: RTL and testbench

Shares one mdio_interface master among N_REQ independent requesters (PHY init sequencer, link monitor, host register bridge).
- Accepts per-requester read/write commands and arbitrates round-robin.
- Drives the master's command inputs and single-cycle begin pulse, then waits for finish.
- Returns read data and completion or timeout status to the winning requester.
- Sits directly above mdio_interface in the iclk_100m domain.

---
 rtl/mdio_pkg.sv | 17 +
 rtl/mdio_rr_arbiter.sv | 33 +++
 rtl/mdio_cmd_arbiter.sv | 138 +++++++++++++
 tb/tb_mdio_cmd_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared encodings, state type and field widths for the MDIO command arbiter.
package mdio_pkg;

  localparam logic [1:0] MDIO_OP_READ  = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b10;

  localparam int PHY_ADDR_W = 5;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FIN, DONE} mdio_state_e;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == MDIO_OP_READ) || (op == MDIO_OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module mdio_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos     = (int'(rr_ptr) + i) % N_REQ;
      pos_idx = IDX_W'(pos);
      if (!grant_vld && req[pos_idx]) begin
        grant_vld      = 1'b1;
        grant[pos_idx] = 1'b1;
        grant_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/mdio_cmd_arbiter.sv
// Round-robin sharing of one mdio_interface master among N_REQ command requesters.
// state    | meaning
// IDLE     | wait for master idle and a request; grant winner, latch its command
// ISSUE    | pulse o_operation_begin, clear timeout timer
// WAIT_FIN | wait for finish (capture read data) or timeout
// DONE     | pulse o_req_done with rdata/err, advance rr_ptr past winner
module mdio_cmd_arbiter
  import mdio_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int TMR_W          = 16
) (
  input  logic                       iclk_100m,
  input  logic                       sys_rst_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [2*N_REQ-1:0]         i_req_op,
  input  logic [PHY_ADDR_W*N_REQ-1:0] i_req_phy_addr,
  input  logic [REG_ADDR_W*N_REQ-1:0] i_req_reg_addr,
  input  logic [DATA_W*N_REQ-1:0]    i_req_wdata,
  output logic [N_REQ-1:0]           o_req_grant,
  output logic [N_REQ-1:0]           o_req_done,
  output logic [DATA_W-1:0]          o_req_rdata,
  output logic                       o_req_err,
  output logic [1:0]                 o_operation,
  output logic [PHY_ADDR_W-1:0]      o_phy_addr,
  output logic [REG_ADDR_W-1:0]      o_reg_addr,
  output logic [DATA_W-1:0]          o_master_write_data,
  output logic                       o_operation_begin,
  input  logic [DATA_W-1:0]          i_master_read_data,
  input  logic                       i_master_read_data_valid,
  input  logic                       i_operation_finish,
  input  logic                       i_mdio_master_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  mdio_state_e       state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  cur_idx;
  logic [1:0]        cur_op;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [N_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]  win_idx;
  logic              win_vld;
  logic [1:0]        win_op;

  mdio_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (PTR_W)
  ) u_rr_arbiter (
    .req       (i_req),
    .rr_ptr    (rr_ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .grant_vld (win_vld)
  );

  assign win_op = i_req_op[2*win_idx +: 2];

  always_ff @(posedge iclk_100m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      cur_idx             <= '0;
      cur_op              <= '0;
      timer               <= '0;
      rdata_q             <= '0;
      err_q               <= 1'b0;
      o_req_grant         <= '0;
      o_req_done          <= '0;
      o_req_rdata         <= '0;
      o_req_err           <= 1'b0;
      o_operation         <= '0;
      o_phy_addr          <= '0;
      o_reg_addr          <= '0;
      o_master_write_data <= '0;
      o_operation_begin   <= 1'b0;
    end else begin
      o_req_grant       <= '0;
      o_req_done        <= '0;
      o_req_rdata       <= '0;
      o_req_err         <= 1'b0;
      o_operation_begin <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_mdio_master_busy && win_vld) begin
            o_req_grant <= win_onehot;
            cur_idx     <= win_idx;
            cur_op      <= win_op;
            rdata_q     <= '0;
            // invalid ops complete with error and never touch the master
            if (op_is_valid(win_op)) begin
              o_operation         <= win_op;
              o_phy_addr          <= i_req_phy_addr[PHY_ADDR_W*win_idx +: PHY_ADDR_W];
              o_reg_addr          <= i_req_reg_addr[REG_ADDR_W*win_idx +: REG_ADDR_W];
              o_master_write_data <= i_req_wdata[DATA_W*win_idx +: DATA_W];
              err_q               <= 1'b0;
              state               <= ISSUE;
            end else begin
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          o_operation_begin <= 1'b1;
          timer             <= '0;
          state             <= WAIT_FIN;
        end
        WAIT_FIN: begin
          if (i_master_read_data_valid) rdata_q <= i_master_read_data;
          if (i_operation_finish) begin
            err_q <= 1'b0;
            state <= DONE;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          o_req_done  <= N_REQ'(1) << cur_idx;
          o_req_err   <= err_q;
          o_req_rdata <= (cur_op == MDIO_OP_READ) ? rdata_q : '0;
          rr_ptr      <= (cur_idx == PTR_W'(N_REQ - 1)) ? '0 : cur_idx + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_cmd_arbiter.sv
// Directed plus randomized bench for mdio_cmd_arbiter with a round-robin reference model.
module tb_mdio_cmd_arbiter;

  localparam int N  = 4;
  localparam int TO = 40;
  localparam int TW = 8;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic          clk;
  logic          sys_rst_n;
  logic [N-1:0]  req_v;
  logic [2*N-1:0]  req_op;
  logic [5*N-1:0]  req_phy;
  logic [5*N-1:0]  req_reg;
  logic [16*N-1:0] req_wd;
  logic [N-1:0]  o_req_grant, o_req_done;
  logic [15:0]   o_req_rdata;
  logic          o_req_err;
  logic [1:0]    o_operation;
  logic [4:0]    o_phy_addr, o_reg_addr;
  logic [15:0]   o_master_write_data;
  logic          o_operation_begin;
  logic [15:0]   rdata_in;
  logic          rvalid, fin, busy;

  logic [1:0]  op_a  [N];
  logic [4:0]  phy_a [N];
  logic [4:0]  reg_a [N];
  logic [15:0] wd_a  [N];
  logic [15:0] rd_a  [N];

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  int begin_cnt = 0;

  mdio_cmd_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .TMR_W(TW)) dut (
    .iclk_100m                (clk),
    .sys_rst_n                (sys_rst_n),
    .i_req                    (req_v),
    .i_req_op                 (req_op),
    .i_req_phy_addr           (req_phy),
    .i_req_reg_addr           (req_reg),
    .i_req_wdata              (req_wd),
    .o_req_grant              (o_req_grant),
    .o_req_done               (o_req_done),
    .o_req_rdata              (o_req_rdata),
    .o_req_err                (o_req_err),
    .o_operation              (o_operation),
    .o_phy_addr               (o_phy_addr),
    .o_reg_addr               (o_reg_addr),
    .o_master_write_data      (o_master_write_data),
    .o_operation_begin        (o_operation_begin),
    .i_master_read_data       (rdata_in),
    .i_master_read_data_valid (rvalid),
    .i_operation_finish       (fin),
    .i_mdio_master_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]   = op_a[i];
      req_phy[5*i +: 5]  = phy_a[i];
      req_reg[5*i +: 5]  = reg_a[i];
      req_wd[16*i +: 16] = wd_a[i];
    end
  end

  always @(posedge clk) if (o_operation_begin === 1'b1) begin_cnt <= begin_cnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner(input int ptr, input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  task automatic set_req(input int k, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] rd);
    op_a[k] = op; phy_a[k] = phy; reg_a[k] = rg; wd_a[k] = wd; rd_a[k] = rd;
    req_v[k] = 1'b1;
  endtask

  task automatic rand_req(input int k);
    int p;
    logic [1:0] op;
    p  = int'($urandom_range(0, 9));
    op = (p < 4) ? RD : (p < 8) ? WR : (p == 8) ? 2'b11 : 2'b00;
    set_req(k, op, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // One complete transaction for the requester the model predicts will win.
  task automatic serve(input int lat, input bit hang, output int k);
    int n, b0;
    logic [1:0] op;
    bit vop, exp_err;
    logic [15:0] exp_rd;
    k   = exp_winner(ptr_m, req_v);
    op  = op_a[k];
    vop = (op == RD) || (op == WR);
    b0  = begin_cnt;
    n   = 0;
    while (o_req_grant == '0 && n < 100) begin tick(); n++; end
    check("grant_vec", 32'(o_req_grant), 32'(1) << k);
    check("grant_latency", 32'(n), 1);
    req_v[k] = 1'b0;
    if (vop) begin
      check("cmd_fields", {4'h0, o_operation, o_phy_addr, o_reg_addr, o_master_write_data},
            {4'h0, op, phy_a[k], reg_a[k], wd_a[k]});
      tick();
      check("begin_pulse", 32'(o_operation_begin), 1);
      check("cmd_hold", {4'h0, o_operation, o_phy_addr, o_reg_addr, o_master_write_data},
            {4'h0, op, phy_a[k], reg_a[k], wd_a[k]});
      busy = 1'b1;
      exp_err = hang ? 1'b1 : (lat + 1 > TO);
      n = 0;
      if (!hang) begin
        repeat (lat) begin tick(); n++; end
        fin = 1'b1; rvalid = (op == RD); rdata_in = rd_a[k];
        tick(); n++;
        fin = 1'b0; rvalid = 1'b0; rdata_in = 16'($urandom); busy = 1'b0;
      end
      while (o_req_done == '0 && n < TO + 10) begin tick(); n++; end
      if (hang) check("timeout_latency", 32'(n >= TO && n <= TO + 1), 1);
      busy = 1'b0;
    end else begin
      exp_err = 1'b1;
      n = 0;
      while (o_req_done == '0 && n < 10) begin tick(); n++; end
    end
    exp_rd = (op == RD && !exp_err) ? rd_a[k] : 16'h0000;
    check("done_vec", 32'(o_req_done), 32'(1) << k);
    check("done_rdata", 32'(o_req_rdata), 32'(exp_rd));
    check("done_err", 32'(o_req_err), 32'(exp_err));
    check("begin_count", 32'(begin_cnt - b0), vop ? 1 : 0);
    ptr_m = (k + 1) % N;
  endtask

  initial begin
    int k;
    logic seen;
    sys_rst_n = 1'b0; req_v = '0; rdata_in = '0; rvalid = 1'b0; fin = 1'b0; busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; phy_a[i] = '0; reg_a[i] = '0; wd_a[i] = '0; rd_a[i] = '0;
    end
    tick(); tick();
    check("reset_strobes", {28'h0, o_req_grant, o_req_done} | {31'h0, o_operation_begin}, 0);
    check("reset_cmd", {4'h0, o_operation, o_phy_addr, o_reg_addr, o_master_write_data}, 0);
    check("reset_resp", {15'h0, o_req_err, o_req_rdata}, 0);
    sys_rst_n = 1'b1;
    tick();

    // single read and single write
    set_req(0, RD, 5'b01101, 5'b01100, 16'h5555, 16'hAAAA);
    serve(3, 0, k);
    set_req(2, WR, 5'h03, 5'h11, 16'h1234, 16'hBEEF);
    serve(2, 0, k);

    // invalid op must move the pointer to 2, so 2 beats 1 next
    set_req(1, 2'b11, 5'h01, 5'h02, 16'h0F0F, 16'h0);
    serve(0, 0, k);
    set_req(1, RD, 5'h04, 5'h05, 16'h0, 16'h1111);
    set_req(2, RD, 5'h06, 5'h07, 16'h0, 16'h2222);
    serve(1, 0, k);
    check("ptr_after_invalid", 32'(k), 2);
    serve(1, 0, k);

    // four-way contention with re-requests
    for (int i = 0; i < N; i++) set_req(i, (i % 2) ? WR : RD, 5'(i), 5'(i + 8), 16'(16'h100 * i), 16'(16'hC000 + i));
    for (int i = 0; i < 5; i++) begin
      serve(i, 0, k);
      if (i < 4) set_req(k, RD, 5'(k + 16), 5'(k), 16'h0, 16'(16'hD000 + i));
    end
    while (req_v != '0) serve(2, 0, k);

    // timeout, late finish ignored, then normal service
    set_req(3, RD, 5'h1F, 5'h1E, 16'h0, 16'h7777);
    serve(0, 1, k);
    fin = 1'b1; tick(); fin = 1'b0;
    seen = 1'b0;
    repeat (4) begin tick(); seen = seen | (|o_req_done) | o_operation_begin; end
    check("late_finish_ignored", 32'(seen), 0);
    set_req(0, WR, 5'h02, 5'h03, 16'hCAFE, 16'h0);
    serve(1, 0, k);

    // finish on the last allowed cycle wins; one later loses
    set_req(1, RD, 5'h0A, 5'h0B, 16'h0, 16'h3C3C);
    serve(TO - 1, 0, k);
    set_req(1, RD, 5'h0A, 5'h0B, 16'h0, 16'h4D4D);
    serve(TO, 0, k);

    // busy hold-off with a withdrawn request
    busy = 1'b1;
    set_req(0, RD, 5'h08, 5'h09, 16'h0, 16'h0880);
    set_req(3, WR, 5'h08, 5'h09, 16'h9999, 16'h0);
    seen = 1'b0;
    repeat (3) begin tick(); seen = seen | (|o_req_grant); end
    req_v[3] = 1'b0;
    repeat (5) begin tick(); seen = seen | (|o_req_grant); end
    check("busy_holdoff", 32'(seen), 0);
    busy = 1'b0;
    serve(2, 0, k);

    // reset during WAIT_FIN
    set_req(2, RD, 5'h15, 5'h16, 16'h0, 16'h1357);
    tick(); req_v[2] = 1'b0; tick(); busy = 1'b1; tick(); tick();
    sys_rst_n = 1'b0;
    #1;
    check("midrst_strobes", {28'h0, o_req_grant, o_req_done} | {31'h0, o_operation_begin}, 0);
    check("midrst_cmd", {4'h0, o_operation, o_phy_addr, o_reg_addr, o_master_write_data}, 0);
    check("midrst_resp", {15'h0, o_req_err, o_req_rdata}, 0);
    ptr_m = 0;
    tick();
    set_req(1, RD, 5'h11, 5'h12, 16'h0, 16'h2468);
    set_req(2, WR, 5'h13, 5'h14, 16'hABCD, 16'h0);
    tick();
    sys_rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin tick(); seen = seen | (|o_req_grant) | (|o_req_done); end
    fin = 1'b1; tick(); fin = 1'b0;
    repeat (3) begin tick(); seen = seen | (|o_req_grant) | (|o_req_done); end
    check("busy_after_reset", 32'(seen), 0);
    busy = 1'b0;
    serve(1, 0, k);
    check("ptr_after_reset", 32'(k), 1);
    serve(1, 0, k);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (req_v == '0) rand_req(int'($urandom_range(0, N - 1)));
      serve(int'($urandom_range(0, 5)), 0, k);
      for (int i = 0; i < N; i++)
        if (!req_v[i] && $urandom_range(0, 2) == 0) rand_req(i);
    end
    while (req_v != '0) serve(int'($urandom_range(0, 5)), 0, k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
